// File: rtl/plma_result_decoder_if.sv
// rtl/plma_result_decoder_if.sv - request/result bundle between the PLMA result producer and the decoder
//
// Purpose: carries one float-to-BCD conversion request and its result.
// Signals:
//   start  - request strobe, sampled by the decoder only when idle
//   value  - IEEE-754 single-precision result to convert
//   ovf_in - arithmetic-unit overflow, latched together with value
//   busy   - conversion in progress
//   done   - one-cycle pulse when sign/bcd/err are updated
//   sign   - displayed value is negative
//   bcd    - packed BCD, [27:12] integer digits, [11:0] fraction digits
//   err    - result not representable
// Modports: master drives the request, slave (the decoder) drives the result.
interface plma_result_decoder_if;
    logic        start;
    logic [31:0] value;
    logic        ovf_in;
    logic        busy;
    logic        done;
    logic        sign;
    logic [27:0] bcd;
    logic        err;

    modport master (
        output start, value, ovf_in,
        input  busy, done, sign, bcd, err
    );

    modport slave (
        input  start, value, ovf_in,
        output busy, done, sign, bcd, err
    );
endinterface

// File: rtl/plma_result_decoder.sv
// rtl/plma_result_decoder.sv - IEEE-754 single to signed 4.3-digit packed-BCD display converter
//
// Purpose: multi-cycle conversion of the PLMA arithmetic result into a signed
// fixed-format decimal value (4 integer + 3 fraction BCD digits), fixed
// latency of 27 clocks from the start-sampling edge to the done pulse.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - plma_result_decoder_if.slave (start/value/ovf_in in,
//         busy/done/sign/bcd/err out, all outputs registered)
module plma_result_decoder #(
    parameter int FRAC_DIGITS = 3,
    parameter int INT_DIGITS  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    plma_result_decoder_if.slave   bus
);

    localparam int NDIG  = INT_DIGITS + FRAC_DIGITS;
    localparam int BCD_W = 4 * NDIG;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_SCALE,
        S_CONV,
        S_FINISH
    } state_t;

    state_t             r_state;
    logic [31:0]        r_value;
    logic               r_ovf;
    logic [7:0]         r_exp;
    logic [23:0]        r_mant;
    logic               r_err_flag;
    logic               r_zero;
    logic [23:0]        r_n;
    logic               r_nz;
    logic [BCD_W-1:0]   r_digits;
    logic [4:0]         r_cnt;

    logic               r_busy;
    logic               r_done;
    logic               r_sign;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_err;

    // Scaling datapath: N = round_half_up(m * 1000 / 2^k), k = 150 - e
    logic [33:0]        w_prod;
    logic [8:0]         w_k;
    logic [34:0]        w_round;
    logic [34:0]        w_sum;
    logic [34:0]        w_shifted;
    logic [23:0]        w_n;
    logic               w_big;
    logic [23:0]        w_n_final;
    logic [BCD_W-1:0]   w_adj;

    // m * 1000 = m * (1024 - 16 - 8)
    assign w_prod = ({10'd0, r_mant} << 10) - ({10'd0, r_mant} << 4) - ({10'd0, r_mant} << 3);

    // For exponents above 150 the subtraction wraps to a large value, which
    // lands in the "N = 0" branch; those exponents are already flagged errors.
    assign w_k = 9'd150 - {1'b0, r_exp};

    assign w_round   = (w_k >= 9'd1 && w_k <= 9'd34) ? (35'd1 << (w_k - 9'd1)) : 35'd0;
    assign w_sum     = {1'b0, w_prod} + w_round;
    assign w_shifted = w_sum >> w_k;
    assign w_n       = (w_k >= 9'd35) ? 24'd0 : w_shifted[23:0];

    // Upper bits can only be set when the exponent is already out of range,
    // but treating them as overflow keeps the truncation safe.
    assign w_big     = (w_n > 24'd9999999) || (|w_shifted[34:24]);

    assign w_n_final = (r_err_flag || r_zero || w_big) ? 24'd0 : w_n;

    // Double-dabble correction: add 3 to every digit >= 5 before shifting.
    always_comb begin
        w_adj = r_digits;
        for (int i = 0; i < NDIG; i++) begin
            if (r_digits[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_digits[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_value    <= '0;
            r_ovf      <= 1'b0;
            r_exp      <= '0;
            r_mant     <= '0;
            r_err_flag <= 1'b0;
            r_zero     <= 1'b0;
            r_n        <= '0;
            r_nz       <= 1'b0;
            r_digits   <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sign     <= 1'b0;
            r_bcd      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_value <= bus.value;
                        r_ovf   <= bus.ovf_in;
                        r_busy  <= 1'b1;
                        r_state <= S_UNPACK;
                    end
                end

                S_UNPACK: begin
                    r_exp      <= r_value[30:23];
                    r_mant     <= {1'b1, r_value[22:0]};
                    // e >= 141 means |v| >= 16384; e == 255 is NaN/inf
                    r_err_flag <= (r_value[30:23] == 8'd255) || (r_value[30:23] >= 8'd141) || r_ovf;
                    // denormals are flushed to zero
                    r_zero     <= (r_value[30:23] == 8'd0);
                    r_state    <= S_SCALE;
                end

                S_SCALE: begin
                    r_err_flag <= r_err_flag || w_big;
                    r_n        <= w_n_final;
                    r_nz       <= (w_n_final != 24'd0);
                    r_digits   <= '0;
                    r_cnt      <= '0;
                    r_state    <= S_CONV;
                end

                S_CONV: begin
                    {r_digits, r_n} <= {w_adj[BCD_W-2:0], r_n, 1'b0};
                    r_cnt           <= r_cnt + 5'd1;
                    if (r_cnt == 5'd23) begin
                        r_state <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    r_bcd   <= r_digits;
                    r_err   <= r_err_flag;
                    // negative zero and error results display as positive
                    r_sign  <= r_value[31] && !r_err_flag && r_nz;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sign = r_sign;
    assign bus.bcd  = r_bcd;
    assign bus.err  = r_err;

endmodule

// File: doc/plma_result_decoder.md
Name: plma_result_decoder

Overview:
- Converts the 32-bit IEEE-754 single-precision result of the PLMA arithmetic unit into a signed, fixed-format decimal display value: 4 integer digits and 3 fraction digits in packed BCD.
- It is the output-side counterpart of the operand encoder. It sits between the arithmetic unit's result/overflow outputs and the display driver.
- It is multi-cycle, with a start/busy/done handshake and a fixed latency.

Parameters:
- FRAC_DIGITS, 3, number of fraction digits. This sets the scale factor 10^3 = 1000. Only 3 is supported.
- INT_DIGITS, 4, number of integer digits. Only 4 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to convert `value`. Sampled only when the block is idle.
- value  input  32  IEEE-754 single to convert.
- ovf_in  input  1  overflow flag from the arithmetic unit. Latched with `value`; forces an error result.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when `bcd`, `sign` and `err` are updated.
- sign  output  1  1 means the displayed value is negative.
- bcd  output  28  packed BCD. Bits [27:12] hold the integer digits, most significant first. Bits [11:0] hold the fraction digits.
- err  output  1  result not representable: NaN, infinity, |v| ≥ 10000 after rounding, or ovf_in set.

Behaviour:
- Reset:
  - busy=0, done=0, sign=0, bcd=0, err=0, state IDLE.
  - Reset asserted mid-conversion aborts it. No done pulse is produced and outputs return to their reset values.
- States: IDLE → UNPACK → SCALE → CONV (24 cycles) → FINISH → IDLE.
- IDLE:
  - start=1 at a rising edge latches value and ovf_in, sets busy=1 from the next cycle, and moves to UNPACK.
  - start while busy is ignored, with no queueing.
- UNPACK:
  - e = value[30:23]; m = {1, value[22:0]} (24 bits).
  - If e==255, or e≥141 (|v| ≥ 16384), or ovf_in: set the error flag.
  - If e==0: zero flag set. Denormals are flushed to zero.
- SCALE:
  - P = m·1000, 34 bits, computed as (m<<10) − (m<<4) − (m<<3).
  - k = 150 − e.
  - If k ≥ 35: N = 0.
  - Otherwise: N = (P + 2^(k−1)) >> k. This rounds half up.
  - Keep N in 24 bits.
  - If N > 9999999: set the error flag.
  - If the error or zero flag is set: N = 0.
- CONV: double-dabble of N into 7 BCD digits.
  - One bit per cycle, exactly 24 cycles.
  - Before each shift, add 3 to every digit ≥ 5.
- FINISH (one cycle):
  - bcd ← converted digits.
  - err ← error flag.
  - sign ← value[31] AND NOT error AND N≠0, so negative zero displays as +0.
  - done=1 for this cycle only; busy=0 on the following cycle.
- Latency: done is high exactly 27 clocks after the edge that sampled start. The latency is the same for every input, including error and zero cases.
- Output stability: bcd, sign and err hold their values between done pulses and change only in FINISH.
- Back-to-back operation: start may be asserted in the cycle after done. The next conversion is accepted in IDLE.
- On error: bcd=0, sign=0, err=1.

Test Plan:
- Reset behaviour: rst pulse during CONV of 0x41500000 → busy=0, done never pulses, bcd=0x0000000 and sign=0 immediately after reset.
- 0xC2613333 (−56.3) → after exactly 27 clocks: done=1, sign=1, bcd=0x0056300, err=0. Also verify busy=1 for clocks 1–26 and start ignored while busy.
- 0x41500000 (13.0) → bcd=0x0013000, sign=0. Then, back-to-back, 0x3F800000 (1.0) → bcd=0x0001000.
- 0x461C3C00 (9999.0) → bcd=0x9999000, err=0.
- 0x46800000 (16384.0) → err=1, bcd=0.
- 0x7F800000 (+inf) → err=1, bcd=0.
- 0x41500000 with ovf_in=1 → err=1, bcd=0.
- Rounding and zero:
  - 0x3A83126F (≈0.001) → bcd=0x0000001.
  - 0x3A000000 (2^−11) → bcd=0x0000000, sign=0.
  - 0x80000000 (−0) → sign=0, bcd=0, err=0.
